// File: rtl/sipo_deser_if.sv
// sipo_deser_if: serial-in and parallel-out signal bundle of the deserializer.
// slave is the deserializer side; master is the link/consumer side.
interface sipo_deser_if #(
  parameter int WIDTH = 4
);
  logic             si;
  logic             si_valid;
  logic             sync;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready;
  logic             overrun;
  logic             par_err;

  modport master (
    output si, si_valid, sync, po_ready,
    input  po, po_valid, overrun, par_err
  );

  modport slave (
    input  si, si_valid, sync, po_ready,
    output po, po_valid, overrun, par_err
  );
endinterface

// File: rtl/sipo_deser.sv
// sipo_deser: MSB-first serial to WIDTH-bit word, sync-aligned, held output.
// Define SIPO_PARITY_EN for a trailing even-parity bit per frame.
module sipo_deser #(
  parameter int WIDTH = 4
) (
  input logic        clk,
  input logic        rst_n,
  sipo_deser_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT
`ifdef SIPO_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             po_valid_q, po_valid_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] sr_shl;
  logic [CW-1:0]    cnt_next;
  logic             take, done, dlv;
  logic [WIDTH-1:0] dlv_word;

  // shift left by one; works for WIDTH=1 as well
  assign sr_shl   = WIDTH'({sr_q, bus.si});
  assign cnt_next = bus.sync ? CW'(1) : cnt_q + CW'(1);
  assign done     = (cnt_next == CW'(WIDTH));

`ifdef SIPO_PARITY_EN
  logic par_err_q, par_err_d;
`endif

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    take     = 1'b0;
    dlv      = 1'b0;
    dlv_word = sr_shl;
`ifdef SIPO_PARITY_EN
    par_err_d = 1'b0;
`endif
    if (bus.si_valid) begin
      case (state_q)
        S_IDLE:  take = bus.sync;
        S_SHIFT: take = 1'b1;
`ifdef SIPO_PARITY_EN
        S_PARITY: begin
          if (bus.sync) begin
            take = 1'b1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
            if (^{sr_q, bus.si} == 1'b0) begin
              dlv      = 1'b1;
              dlv_word = sr_q;
            end else begin
              par_err_d = 1'b1;
            end
          end
        end
`endif
        default: take = 1'b0;
      endcase
    end
    if (take) begin
      sr_d    = sr_shl;
      cnt_d   = cnt_next;
      state_d = S_SHIFT;
      if (done) begin
`ifdef SIPO_PARITY_EN
        state_d = S_PARITY;
`else
        state_d = S_IDLE;
        cnt_d   = '0;
        dlv     = 1'b1;
`endif
      end
    end
  end

  // a delivery may land in the same cycle the consumer drains po
  always_comb begin
    po_d       = po_q;
    po_valid_d = po_valid_q;
    overrun_d  = 1'b0;
    if (dlv) begin
      if (!po_valid_q || bus.po_ready) begin
        po_d       = dlv_word;
        po_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (po_valid_q && bus.po_ready) begin
      po_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      po_q       <= '0;
      po_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      po_q       <= po_d;
      po_valid_q <= po_valid_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end
  assign bus.par_err = par_err_q;
`else
  assign bus.par_err = 1'b0;
`endif

  assign bus.po       = po_q;
  assign bus.po_valid = po_valid_q;
  assign bus.overrun  = overrun_q;
endmodule
